// File: rtl/usr_seq_driver_if.sv
// Byte-source handshake plus USR control bundle for usr_seq_driver.
// The master side offers bytes and watches the USR controls; the slave side is the driver.
interface usr_seq_driver_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_dir;
  logic             in_pload;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       select;
  logic [WIDTH-1:0] pload;
  logic             L_in;
  logic             R_in;
  logic             busy;
  logic             done;

  modport master (
    output in_data, in_dir, in_pload, in_valid,
    input  in_ready, select, pload, L_in, R_in, busy, done
  );

  modport slave (
    input  in_data, in_dir, in_pload, in_valid,
    output in_ready, select, pload, L_in, R_in, busy, done
  );
endinterface

// File: rtl/usr_seq_driver.sv
// Serialises accepted bytes into an 8-bit universal shift register, one bit per clock.
// Define USR_SEQ_PLOAD_EN to add a one-cycle parallel-load path (LOAD state).
module usr_seq_driver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  usr_seq_driver_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

`ifdef USR_SEQ_PLOAD_EN
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] sh, sh_d;
  logic [1:0]       sel, sel_d;
  logic             l_q, l_d;
  logic             r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef USR_SEQ_PLOAD_EN
  logic [WIDTH-1:0] pload_q, pload_d;
`else
  logic             unused_pload;
  assign unused_pload = bus.in_pload;
`endif

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sh_d    = sh;
    sel_d   = sel;
    l_d     = l_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef USR_SEQ_PLOAD_EN
    pload_d = pload_q;
`endif
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
`ifdef USR_SEQ_PLOAD_EN
          if (bus.in_pload) begin
            state_d = LOAD;
            sel_d   = 2'b11;
            pload_d = bus.in_data;
            busy_d  = 1'b1;
          end else
`endif
          begin
            // First bit is presented straight from the input so it is valid from the accept edge
            state_d = SHIFT;
            sh_d    = bus.in_data;
            cnt_d   = CW'(1);
            busy_d  = 1'b1;
            if (bus.in_dir) begin
              sel_d = 2'b10;
              l_d   = bus.in_data[0];
              r_d   = 1'b0;
            end else begin
              sel_d = 2'b01;
              r_d   = bus.in_data[WIDTH-1];
              l_d   = 1'b0;
            end
          end
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          sel_d   = 2'b00;
          l_d     = 1'b0;
          r_d     = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          // sel doubles as the direction flag for the duration of the transfer
          cnt_d = cnt + CW'(1);
          if (sel == 2'b10) begin
            sh_d = sh >> 1;
            l_d  = sh[1];
          end else begin
            sh_d = sh << 1;
            r_d  = sh[WIDTH-2];
          end
        end
      end
`ifdef USR_SEQ_PLOAD_EN
      LOAD: begin
        state_d = IDLE;
        sel_d   = 2'b00;
        pload_d = '0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      sel    <= 2'b00;
      l_q    <= 1'b0;
      r_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef USR_SEQ_PLOAD_EN
      pload_q <= '0;
`endif
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      sel    <= sel_d;
      l_q    <= l_d;
      r_q    <= r_d;
      busy_q <= busy_d;
      done_q <= done_d;
`ifdef USR_SEQ_PLOAD_EN
      pload_q <= pload_d;
`endif
    end
  end

  // Data shift register carries no reset; it is always loaded before use
  always_ff @(posedge clk) begin
    sh <= sh_d;
  end

  assign bus.in_ready = (state == IDLE);
  assign bus.select   = sel;
  assign bus.L_in     = l_q;
  assign bus.R_in     = r_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
`ifdef USR_SEQ_PLOAD_EN
  assign bus.pload    = pload_q;
`else
  assign bus.pload    = '0;
`endif
endmodule
